// File: rtl/row_matrix_display_if.sv
// Row-write and display bus between the stacker game FSM and the matrix display.
// Latency: not applicable (signal bundle only).
// Backpressure: none; the display accepts a write every cycle.
interface row_matrix_display_if;
  logic [7:0] val;
  logic [2:0] rowIndex;
  logic       writeStrobe;
  logic       clrarray;
  logic [2:0] state;
  logic [2:0] rd_index;
  logic [7:0] rd_data;
  logic [7:0] row_n;
  logic [7:0] col;
  logic       frame_tick;

  modport master (
    output val, rowIndex, writeStrobe, clrarray, state, rd_index,
    input  rd_data, row_n, col, frame_tick
  );

  modport slave (
    input  val, rowIndex, writeStrobe, clrarray, state, rd_index,
    output rd_data, row_n, col, frame_tick
  );
endinterface

// File: rtl/row_matrix_display.sv
// 8x8 playfield store with row-multiplexed LED scan-out and WIN/LOSE blink.
// Latency: writes reach rd_data/col within 1-2 cycles; row_n/col lag scan_row by 1.
// Backpressure: none; every write and clear is accepted on the cycle it is presented.
module row_matrix_display #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  row_matrix_display_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

  typedef enum logic {SHOW = 1'b0, BLANK = 1'b1} blink_t;

  logic [7:0]       r_mem [8];
  logic [7:0]       r_rd_data;
  logic [DIV_W-1:0] r_div_cnt;
  logic [2:0]       r_scan_row;
  logic [7:0]       r_row_n;
  logic [7:0]       r_col;
  logic             r_frame_tick;
  logic [FC_W-1:0]  r_frame_cnt;
  blink_t           r_blink;

  logic             w_row_step;
  logic             w_frame_wrap;
  logic             w_blink_en;
  logic [7:0]       w_row_onehot;
  blink_t           w_blink_next;
  logic [FC_W-1:0]  w_frame_cnt_next;

  assign w_row_step   = (r_div_cnt == DIV_LAST);
  assign w_frame_wrap = w_row_step && (r_scan_row == 3'd7);
  assign w_blink_en   = (bus.state == 3'b101) || (bus.state == 3'b111);
  assign w_row_onehot = 8'h01 << r_scan_row;

  // Playfield storage: clear beats write, so a strobe during clrarray is dropped.
  always_ff @(posedge clk) begin
    if (reset || bus.clrarray) begin
      for (int k = 0; k < 8; k++) begin
        r_mem[k] <= '0;
      end
    end else if (bus.writeStrobe) begin
      r_mem[bus.rowIndex] <= bus.val;
    end
  end

  // Registered readback of the selected row.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_mem[bus.rd_index];
    end
  end

  // Row prescaler and scan row pointer; frame_tick marks the 7->0 wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt    <= '0;
      r_scan_row   <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_frame_wrap;
      if (w_row_step) begin
        r_div_cnt  <= '0;
        r_scan_row <= r_scan_row + 3'd1;
      end else begin
        r_div_cnt  <= r_div_cnt + 1'b1;
      end
    end
  end

  // Registered matrix drive; all rows off during reset, column data blanked in BLANK.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_n <= 8'hFF;
      r_col   <= 8'h00;
    end else begin
      r_row_n <= ~w_row_onehot;
      r_col   <= (r_blink == BLANK) ? 8'h00 : r_mem[r_scan_row];
    end
  end

  // Blink state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_blink     <= SHOW;
      r_frame_cnt <= '0;
    end else begin
      r_blink     <= w_blink_next;
      r_frame_cnt <= w_frame_cnt_next;
    end
  end

  // Blink next-state: count frames while in WIN/LOSE, snap back to SHOW otherwise.
  always_comb begin
    w_blink_next     = r_blink;
    w_frame_cnt_next = r_frame_cnt;
    if (!w_blink_en) begin
      w_blink_next     = SHOW;
      w_frame_cnt_next = '0;
    end else if (w_frame_wrap) begin
      if (r_frame_cnt == FC_LAST) begin
        w_frame_cnt_next = '0;
        w_blink_next     = (r_blink == SHOW) ? BLANK : SHOW;
      end else begin
        w_frame_cnt_next = r_frame_cnt + 1'b1;
      end
    end
  end

  assign bus.rd_data    = r_rd_data;
  assign bus.row_n      = r_row_n;
  assign bus.col        = r_col;
  assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_row_matrix_display.sv
// Directed bench for row_matrix_display with SCAN_DIV=4, BLINK_FRAMES=2.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: none.
module tb_row_matrix_display;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  row_matrix_display_if bus ();

  row_matrix_display #(
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input logic [2:0] idx, input logic [7:0] data);
    bus.writeStrobe = 1'b1;
    bus.rowIndex    = idx;
    bus.val         = data;
    tick();
    bus.writeStrobe = 1'b0;
  endtask

  // Advance until frame_tick is observed; on return we sit just after the wrap edge.
  task automatic sync_frame();
    int n;
    n = 0;
    while (bus.frame_tick !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("sync_frame_tick", {31'd0, bus.frame_tick}, 32'd1);
  endtask

  function automatic logic [7:0] row_exp(input int i);
    logic [7:0] one;
    one = 8'h01 << (((i - 1) / 4) % 8);
    return ~one;
  endfunction

  initial begin
    logic [7:0] exp_col;
    logic [7:0] one;
    total = 0;
    bad   = 0;
    reset           = 1'b1;
    bus.val         = '0;
    bus.rowIndex    = '0;
    bus.writeStrobe = 1'b0;
    bus.clrarray    = 1'b0;
    bus.state       = 3'b000;
    bus.rd_index    = '0;
    repeat (3) tick();
    reset = 1'b0;

    check("rst_row_n",      {24'd0, bus.row_n},   32'hFF);
    check("rst_col",        {24'd0, bus.col},     32'h00);
    check("rst_frame_tick", {31'd0, bus.frame_tick}, 32'd0);
    check("rst_rd_data",    {24'd0, bus.rd_data}, 32'h00);

    // Single write to row 3, read back one cycle later.
    bus.rd_index = 3'd3;
    write_row(3'd3, 8'hE0);
    check("first_row_on", {24'd0, bus.row_n}, 32'hFE);
    tick();
    check("rd_row3", {24'd0, bus.rd_data}, 32'hE0);
    for (int k = 0; k < 8; k++) begin
      if (k != 3) begin
        bus.rd_index = 3'(k);
        tick();
        check("rd_other_zero", {24'd0, bus.rd_data}, 32'h00);
      end
    end

    // Walking-one pattern scanned out during play.
    for (int k = 0; k < 8; k++) begin
      one = 8'h01 << k;
      write_row(3'(k), one);
    end
    bus.state = 3'b001;
    sync_frame();
    for (int i = 1; i <= 32; i++) begin
      tick();
      one = 8'h01 << ((i - 1) / 4);
      check("scan_row_n", {24'd0, bus.row_n}, {24'd0, row_exp(i)});
      check("scan_col",   {24'd0, bus.col},   {24'd0, one});
      check("scan_ftick", {31'd0, bus.frame_tick}, (i == 32) ? 32'd1 : 32'd0);
    end

    // Clear wins over a simultaneous write.
    bus.writeStrobe = 1'b1;
    bus.clrarray    = 1'b1;
    bus.rowIndex    = 3'd2;
    bus.val         = 8'hFF;
    tick();
    bus.writeStrobe = 1'b0;
    bus.clrarray    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.rd_index = 3'(k);
      tick();
      check("clr_rd_zero", {24'd0, bus.rd_data}, 32'h00);
    end

    // Full field, WIN blink, drop to play mid-BLANK, re-enter WIN, reset in BLANK.
    for (int k = 0; k < 8; k++) begin
      write_row(3'(k), 8'hFF);
    end
    sync_frame();
    bus.state = 3'b101;
    for (int i = 1; i <= 213; i++) begin
      tick();
      check("blink_row_n", {24'd0, bus.row_n}, {24'd0, row_exp(i)});
      check("blink_ftick", {31'd0, bus.frame_tick}, (i % 32 == 0) ? 32'd1 : 32'd0);
      if (i != 101) begin
        if (i <= 64)       exp_col = 8'hFF;
        else if (i <= 100) exp_col = 8'h00;
        else if (i <= 192) exp_col = 8'hFF;
        else               exp_col = 8'h00;
        check("blink_col", {24'd0, bus.col}, {24'd0, exp_col});
      end
      if (i == 100) bus.state = 3'b000;
      if (i == 128) bus.state = 3'b101;
    end

    reset = 1'b1;
    tick();
    check("mid_rst_row_n", {24'd0, bus.row_n}, 32'hFF);
    check("mid_rst_col",   {24'd0, bus.col},   32'h00);
    check("mid_rst_ftick", {31'd0, bus.frame_tick}, 32'd0);
    reset        = 1'b0;
    bus.rd_index = 3'd5;
    write_row(3'd0, 8'hAA);
    check("post_rst_row_n", {24'd0, bus.row_n},   32'hFE);
    check("post_rst_mem",   {24'd0, bus.rd_data}, 32'h00);
    tick();
    check("post_rst_show", {24'd0, bus.col}, 32'hAA);
    tick();
    tick();
    check("post_rst_dwell", {24'd0, bus.row_n}, 32'hFE);
    tick();
    check("post_rst_next", {24'd0, bus.row_n}, 32'hFD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
